// File: rtl/anspwm_stage_sched.sv
// rtl/anspwm_stage_sched.sv - round-robin scheduler sharing one ANS-PWM quantize stage across NCH channels
//
// Purpose:
//   Takes one 16-bit target per clock from the requesting channels in round-robin
//   order and drives it to the shared stage's A input. A tag pipeline travels
//   alongside the stage, so each delayed C/Csgn result is returned with the
//   number of the channel that owns it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   enable     in   1 = issue new targets, 0 = stop issuing and drain
//   req        in   [NCH]      per-channel request level, held until granted
//   tgt        in   [NCH*W]    per-channel target, channel i at [i*W +: W]
//   gnt        out  [NCH]      one-hot accept, the target is consumed at this edge
//   stg_a      out  [W]        registered target to the stage A input
//   stg_c      in   [W]        stage C result
//   stg_csgn   in   1          stage C sign
//   res_valid  out  1          one-clock pulse, the result fields are valid
//   res_ch     out  [CW]       channel that owns the result
//   res_c      out  [W]        registered copy of stg_c
//   res_sgn    out  1          registered copy of stg_csgn
//   busy       out  1          high outside IDLE or while any issue is in flight
module anspwm_stage_sched #(
  parameter int NCH = 4,
  parameter int LAT = 3,
  parameter int W   = 16,
  localparam int CW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] tgt,
  output logic [NCH-1:0]   gnt,
  output logic [W-1:0]     stg_a,
  input  logic [W-1:0]     stg_c,
  input  logic             stg_csgn,
  output logic             res_valid,
  output logic [CW-1:0]    res_ch,
  output logic [W-1:0]     res_c,
  output logic             res_sgn,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_rr;
  logic [CW-1:0]   w_sel;
  logic            w_any;
  logic            w_issue;
  logic            w_tag_empty;
  logic [W-1:0]    r_stg_a;
  logic            r_res_valid;
  logic [CW-1:0]   r_res_ch;
  logic [W-1:0]    r_res_c;
  logic            r_res_sgn;

  // Tag entry k moves in step with the stage's k-th register; entry 0 sits
  // beside stg_a and entry LAT sits beside the stage C output, so the return
  // register captures C and its tag at the same edge.
  logic [LAT:0]    r_tag_v;
  logic [CW-1:0]   r_tag_ch [0:LAT];

  // Walk from the farthest channel to the nearest one after r_rr so that the
  // last match, the nearest requester, wins.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_sel = r_rr;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(r_rr) + k) % NCH;
      if (req[idx]) begin
        w_any = 1'b1;
        w_sel = idx[CW-1:0];
      end
    end
  end

  assign w_issue     = (r_state == S_RUN) && enable && w_any;
  assign w_tag_empty = ~|r_tag_v;

  always_comb begin
    gnt = '0;
    if (w_issue) begin
      gnt[w_sel] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Re-enabling while draining resumes issue; in-flight tags keep flowing.
        if (enable) begin
          w_state_nxt = S_RUN;
        end else if (w_tag_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= CW'(NCH - 1);
      r_stg_a <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_rr    <= w_sel;
        r_stg_a <= tgt[int'(w_sel)*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_tag_ch[k] <= '0;
      end
    end else begin
      r_tag_v     <= {r_tag_v[LAT-1:0], w_issue};
      r_tag_ch[0] <= w_sel;
      for (int k = 1; k <= LAT; k++) begin
        r_tag_ch[k] <= r_tag_ch[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_c     <= '0;
      r_res_sgn   <= 1'b0;
    end else begin
      r_res_valid <= r_tag_v[LAT];
      if (r_tag_v[LAT]) begin
        r_res_ch  <= r_tag_ch[LAT];
        r_res_c   <= stg_c;
        r_res_sgn <= stg_csgn;
      end
    end
  end

  assign stg_a     = r_stg_a;
  assign res_valid = r_res_valid;
  assign res_ch    = r_res_ch;
  assign res_c     = r_res_c;
  assign res_sgn   = r_res_sgn;
  assign busy      = (r_state != S_IDLE) || !w_tag_empty;

endmodule
